// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one interval counter among NREQ requesters.
// Each grant runs the counter for max(len,1) cycles, then pulses o_done for the owner.
module timer_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_len,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic [NREQ-1:0]       o_done,
  output logic [WIDTH-1:0]      o_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      idx_q;
  logic [WIDTH-1:0]   len_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;

  logic               sel_vld;
  logic [IW-1:0]      sel_idx;
  logic [NREQ-1:0]    sel_gnt;
  logic [WIDTH-1:0]   sel_len;
  logic [WIDTH-1:0]   last_cnt;

  // Circular search starting just after the last-served index.
  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_gnt = '0;
    sel_len = '0;
    cand    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(ptr_q) + off) % NREQ);
      if (!sel_vld && i_req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (sel_idx == IW'(k)) begin
        sel_gnt[k] = sel_vld;
        sel_len    = i_len[k*WIDTH +: WIDTH];
      end
    end
  end

  // A zero length is run as a single cycle.
  assign last_cnt = (len_q == '0) ? '0 : len_q - WIDTH'(1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            idx_q   <= sel_idx;
            len_q   <= sel_len;
            cnt_q   <= '0;
            gnt_q   <= sel_gnt;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!i_req[idx_q]) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= idx_q;
          end else if (cnt_q == last_cnt) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            done_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        S_DONE: begin
          ptr_q   <= idx_q;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_gnt  = gnt_q;
  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: cycle-exact output checks plus a queue of
// expected o_done pulses pushed when a run is launched and popped when seen.
module tb_timer_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NREQ-1:0] exp_q[$];

  timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_len   (len),
    .o_gnt   (gnt),
    .o_busy  (busy),
    .o_done  (done),
    .o_cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [NREQ-1:0] g, input logic b,
                         input logic [WIDTH-1:0] c, input logic [NREQ-1:0] d);
    check({tag, ".gnt"},  32'(gnt),  32'(g));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".cnt"},  32'(cnt),  32'(c));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Advance one edge, sample 1 time unit later, and retire any done pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done !== '0) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 32'(done), 32'(0));
      else                   check("sb_done", 32'(done), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic set_len(input int k, input logic [WIDTH-1:0] v);
    len[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    len   = '0;

    // Reset state
    #1;
    chk_out("reset", 4'b0000, 1'b0, 8'd0, 4'b0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Single run: req[2], len 3
    req = 4'b0100; set_len(2, 8'd3);
    exp_q.push_back(4'b0100);
    tick(); chk_out("single.c0", 4'b0100, 1'b1, 8'd0, 4'b0000);
    tick(); chk_out("single.c1", 4'b0100, 1'b1, 8'd1, 4'b0000);
    tick(); chk_out("single.c2", 4'b0100, 1'b1, 8'd2, 4'b0000);
    tick(); chk_out("single.done", 4'b0100, 1'b1, 8'd0, 4'b0100);
    req = '0;
    tick(); chk_out("single.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Zero length treated as one
    req = 4'b0001; set_len(0, 8'd0);
    exp_q.push_back(4'b0001);
    tick(); chk_out("zero.c0", 4'b0001, 1'b1, 8'd0, 4'b0000);
    tick(); chk_out("zero.done", 4'b0001, 1'b1, 8'd0, 4'b0001);
    req = '0;
    tick(); chk_out("zero.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Round-robin from fresh reset: order 0,1,2,3,0,1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) set_len(k, 8'd2);
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << (g % NREQ);
      exp_q.push_back(oh);
      tick(); chk_out($sformatf("rr%0d.c0", g), oh, 1'b1, 8'd0, 4'b0000);
      tick(); chk_out($sformatf("rr%0d.c1", g), oh, 1'b1, 8'd1, 4'b0000);
      tick(); chk_out($sformatf("rr%0d.done", g), oh, 1'b1, 8'd0, oh);
      if (g == 5) req = '0;
      tick(); chk_out($sformatf("rr%0d.idle", g), 4'b0000, 1'b0, 8'd0, 4'b0000);
    end

    // Abort: req[1] len 10 dropped at cnt 4; pending req[3] served next
    req = 4'b0010; set_len(1, 8'd10);
    tick(); chk_out("abort.c0", 4'b0010, 1'b1, 8'd0, 4'b0000);
    req = 4'b1010; set_len(3, 8'd1);
    for (int c = 1; c <= 4; c++) begin
      tick(); chk_out($sformatf("abort.c%0d", c), 4'b0010, 1'b1, 8'(c), 4'b0000);
    end
    req = 4'b1000;
    tick(); chk_out("abort.drop", 4'b0000, 1'b0, 8'd0, 4'b0000);
    exp_q.push_back(4'b1000);
    tick(); chk_out("abort.next", 4'b1000, 1'b1, 8'd0, 4'b0000);
    tick(); chk_out("abort.nextdone", 4'b1000, 1'b1, 8'd0, 4'b1000);
    req = '0;
    tick(); chk_out("abort.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Reset mid-run at cnt 5; no done may follow
    req = 4'b0100; set_len(2, 8'd20);
    tick(); chk_out("rstmid.c0", 4'b0100, 1'b1, 8'd0, 4'b0000);
    for (int c = 1; c <= 5; c++) tick();
    chk_out("rstmid.c5", 4'b0100, 1'b1, 8'd5, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk_out("rstmid.async", 4'b0000, 1'b0, 8'd0, 4'b0000);
    tick(); tick();
    chk_out("rstmid.held", 4'b0000, 1'b0, 8'd0, 4'b0000);
    req = 4'b1001; set_len(0, 8'd2); set_len(3, 8'd2);
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    tick(); chk_out("rstmid.g0", 4'b0001, 1'b1, 8'd0, 4'b0000);
    tick(); chk_out("rstmid.g1", 4'b0001, 1'b1, 8'd1, 4'b0000);
    tick(); chk_out("rstmid.done", 4'b0001, 1'b1, 8'd0, 4'b0001);
    req = '0;
    tick(); chk_out("rstmid.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Length change after grant is ignored
    req = 4'b0001; set_len(0, 8'd3);
    exp_q.push_back(4'b0001);
    tick(); chk_out("lenchg.c0", 4'b0001, 1'b1, 8'd0, 4'b0000);
    set_len(0, 8'd7);
    tick(); chk_out("lenchg.c1", 4'b0001, 1'b1, 8'd1, 4'b0000);
    tick(); chk_out("lenchg.c2", 4'b0001, 1'b1, 8'd2, 4'b0000);
    tick(); chk_out("lenchg.done", 4'b0001, 1'b1, 8'd0, 4'b0001);
    req = '0;
    tick(); chk_out("lenchg.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);
    tick(); chk_out("final.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    check("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
